// File: rtl/muldiv_pkg.sv
// Shared types and op-decode helpers for the RV32M multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } md_state_e;

    function automatic logic is_div(input md_op_e op);
        return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    endfunction

    function automatic logic is_rem(input md_op_e op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

    function automatic logic a_signed(input md_op_e op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic b_signed(input md_op_e op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/md_iter_step.sv
// One iteration of the unsigned datapath: shift-add multiply or restoring
// shift-subtract divide on a 2*XLEN accumulator {high, low}.
module md_iter_step #(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN-1:0] i_acc,
    input  logic [XLEN-1:0]   i_opnd,
    input  logic              i_is_div,
    output logic [2*XLEN-1:0] o_acc
);

    logic [XLEN:0] w_sum;
    logic [XLEN:0] w_rem_sh;
    logic [XLEN:0] w_diff;

    always_comb begin
        w_sum    = {1'b0, i_acc[2*XLEN-1:XLEN]} + {1'b0, i_opnd};
        w_rem_sh = i_acc[2*XLEN-1:XLEN-1];
        w_diff   = w_rem_sh - {1'b0, i_opnd};
        if (i_is_div) begin
            // Low half shifts the next dividend bit into the partial remainder and
            // collects quotient bits from the right.
            if (!w_diff[XLEN]) o_acc = {w_diff[XLEN-1:0], i_acc[XLEN-2:0], 1'b1};
            else               o_acc = {w_rem_sh[XLEN-1:0], i_acc[XLEN-2:0], 1'b0};
        end else if (i_acc[0]) begin
            o_acc = {w_sum, i_acc[XLEN-1:1]};
        end else begin
            o_acc = {1'b0, i_acc[2*XLEN-1:1]};
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// Define MULDIV_FAST_MUL_EN for a single-cycle multiplier on MUL* ops.
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            MdStartE,
    input  logic [2:0]      MdOpE,
    input  logic [XLEN-1:0] SrcAE,
    input  logic [XLEN-1:0] SrcBE,
    input  logic            KillE,
    output logic            MdBusyE,
    output logic            MdDoneE,
    output logic [XLEN-1:0] MdResultE
);

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e         r_state;
    md_op_e            r_op;
    logic [CNT_W-1:0]  r_cnt;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_opnd;
    logic [XLEN-1:0]   r_result;
    logic              r_neg;
    logic              r_done;

    md_op_e            w_op;
    logic              w_a_neg, w_b_neg, w_neg, w_accept;
    logic [XLEN-1:0]   w_abs_a, w_abs_b;
    logic              w_early;
    logic [XLEN-1:0]   w_early_res;
    logic [2*XLEN-1:0] w_acc_init, w_acc_next, w_prod_fix;
    logic [XLEN-1:0]   w_div_sel, w_fix_res;

    assign w_op     = md_op_e'(MdOpE);
    assign w_accept = (r_state == S_IDLE) && MdStartE && !KillE;
    assign w_a_neg  = a_signed(w_op) && SrcAE[XLEN-1];
    assign w_b_neg  = b_signed(w_op) && SrcBE[XLEN-1];
    assign w_abs_a  = w_a_neg ? -SrcAE : SrcAE;
    assign w_abs_b  = w_b_neg ? -SrcBE : SrcBE;
    // Remainder follows the dividend; product and quotient follow the XOR.
    assign w_neg    = is_rem(w_op) ? w_a_neg : (w_a_neg ^ w_b_neg);
    assign w_acc_init = is_div(w_op) ? {{XLEN{1'b0}}, w_abs_a} : {{XLEN{1'b0}}, w_abs_b};

`ifdef MULDIV_FAST_MUL_EN
    logic signed [2*XLEN-1:0] w_fast_a, w_fast_b, w_fast_prod;
    assign w_fast_a    = {{XLEN{w_a_neg}}, SrcAE};
    assign w_fast_b    = {{XLEN{w_b_neg}}, SrcBE};
    assign w_fast_prod = w_fast_a * w_fast_b;
`endif

    always_comb begin
        w_early     = 1'b0;
        w_early_res = '0;
        if (is_div(w_op)) begin
            if (SrcBE == '0) begin
                w_early     = 1'b1;
                w_early_res = is_rem(w_op) ? SrcAE : '1;
            end else if (a_signed(w_op) && (SrcAE == INT_MIN) && (SrcBE == '1)) begin
                w_early     = 1'b1;
                w_early_res = is_rem(w_op) ? '0 : INT_MIN;
            end
        end
`ifdef MULDIV_FAST_MUL_EN
        else begin
            w_early     = 1'b1;
            w_early_res = (w_op == OP_MUL) ? w_fast_prod[XLEN-1:0] : w_fast_prod[2*XLEN-1:XLEN];
        end
`endif
    end

    md_iter_step #(.XLEN(XLEN)) u_step (
        .i_acc    (r_acc),
        .i_opnd   (r_opnd),
        .i_is_div (is_div(r_op)),
        .o_acc    (w_acc_next)
    );

    assign w_prod_fix = r_neg ? -r_acc : r_acc;
    assign w_div_sel  = is_rem(r_op) ? r_acc[2*XLEN-1:XLEN] : r_acc[XLEN-1:0];

    always_comb begin
        if (is_div(r_op))         w_fix_res = r_neg ? -w_div_sel : w_div_sel;
        else if (r_op == OP_MUL)  w_fix_res = w_prod_fix[XLEN-1:0];
        else                      w_fix_res = w_prod_fix[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op   <= w_op;
                        r_cnt  <= '0;
                        r_acc  <= w_acc_init;
                        r_opnd <= is_div(w_op) ? w_abs_b : w_abs_a;
                        r_neg  <= w_neg;
                        if (w_early) begin
                            r_result <= w_early_res;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_state  <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (KillE) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_acc <= w_acc_next;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == CNT_LAST) r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (KillE) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_result <= w_fix_res;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: r_state <= S_IDLE;
            endcase
        end
    end

    assign MdBusyE   = w_accept || (r_state == S_CALC) || (r_state == S_FIX);
    assign MdDoneE   = r_done;
    assign MdResultE = r_result;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: directed ops push expected results,
// a negedge monitor pops and checks value and completion cycle.
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        MdStartE;
    logic [2:0]  MdOpE;
    logic [31:0] SrcAE, SrcBE;
    logic        KillE;
    logic        MdBusyE, MdDoneE;
    logic [31:0] MdResultE;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 34;
`endif
    localparam int DIV_LAT = 34;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          issue;
        string       name;
    } exp_t;

    exp_t exp_q[$];

    ex_muldiv_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .MdStartE  (MdStartE),
        .MdOpE     (MdOpE),
        .SrcAE     (SrcAE),
        .SrcBE     (SrcBE),
        .KillE     (KillE),
        .MdBusyE   (MdBusyE),
        .MdDoneE   (MdDoneE),
        .MdResultE (MdResultE)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst === 1'b1 && MdDoneE === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done got result %h expected no done", MdResultE);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.name, "_result"}, MdResultE, e.res);
                check({e.name, "_latency"}, 32'(cyc - e.issue), 32'(e.lat));
            end
        end
    end

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input string name);
        exp_t e;
        int   nbusy;
        bit   got;
        @(posedge clk);
        #1;
        e.res = exp; e.lat = lat; e.issue = cyc; e.name = name;
        exp_q.push_back(e);
        MdStartE = 1'b1; MdOpE = op; SrcAE = a; SrcBE = b;
        nbusy = 0;
        got   = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (MdBusyE) nbusy++;
            if (MdDoneE) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout got no done expected done within 100 cycles", name);
            void'(exp_q.pop_back());
        end
        check({name, "_busy_cycles"}, 32'(nbusy), 32'(lat));
        @(posedge clk);
        #1;
        MdStartE = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected bench completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; MdStartE = 1'b0; MdOpE = 3'd0; SrcAE = '0; SrcBE = '0; KillE = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_done", {31'b0, MdDoneE}, 32'd0);
        check("reset_busy", {31'b0, MdBusyE}, 32'd0);
        check("reset_result", MdResultE, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        run_op(3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, "mul");
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, "mulhu");
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, MUL_LAT, "mulhsu");
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT, "mulh");
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, DIV_LAT, "div");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, DIV_LAT, "rem");
        run_op(3'd5, 32'd100,      32'd0,        32'hFFFF_FFFF, 1,       "divu_by0");
        run_op(3'd6, 32'd100,      32'd0,        32'd100,       1,       "rem_by0");
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,     "div_ovf");
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        1,      "rem_ovf");
        run_op(3'd5, 32'd100,      32'd7,        32'd14,        DIV_LAT, "divu");

        // Kill a DIV in cycle 10; start stays high so only the FSM state can drop busy.
        @(posedge clk);
        #1;
        MdStartE = 1'b1; MdOpE = 3'd4; SrcAE = 32'hFFFF_FFF9; SrcBE = 32'd2;
        repeat (10) @(posedge clk);
        #1 KillE = 1'b1;
        @(negedge clk);
        check("kill_busy_c10", {31'b0, MdBusyE}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("kill_busy_c11", {31'b0, MdBusyE}, 32'd0);
        check("kill_done_c11", {31'b0, MdDoneE}, 32'd0);
        @(posedge clk);
        #1;
        KillE = 1'b0; MdStartE = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("kill_result_held", MdResultE, 32'd14);
        run_op(3'd5, 32'd9, 32'd3, 32'd3, DIV_LAT, "divu_after_kill");

        // Reset in cycle 5 of a DIV.
        @(posedge clk);
        #1;
        MdStartE = 1'b1; MdOpE = 3'd4; SrcAE = 32'd1000; SrcBE = 32'd3;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0; MdStartE = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_done", {31'b0, MdDoneE}, 32'd0);
        check("midrst_busy", {31'b0, MdBusyE}, 32'd0);
        check("midrst_result", MdResultE, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        run_op(3'd7, 32'd100, 32'd7, 32'd2, DIV_LAT, "remu_after_rst");

        repeat (5) @(posedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
